// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
// The master issues operations; the slave (muldiv_unit) returns HI/LO write pulses.
interface muldiv_unit_if #(
  parameter int REG_LENGTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [REG_LENGTH-1:0] opA;
  logic [REG_LENGTH-1:0] opB;
  logic                  cancel;
  logic                  busy;
  logic                  hiWtCe;
  logic                  loWtCe;
  logic [REG_LENGTH-1:0] hiWtData;
  logic [REG_LENGTH-1:0] loWtData;

  modport master (
    output start, op, opA, opB, cancel,
    input  busy, hiWtCe, loWtCe, hiWtData, loWtData
  );

  modport slave (
    input  start, op, opA, opB, cancel,
    output busy, hiWtCe, loWtCe, hiWtData, loWtData
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multiply/divide unit: single-cycle signed/unsigned multiply, radix-2 restoring
// divide (one quotient bit per clock), one-cycle HI/LO write pulse on completion.
module muldiv_unit #(
  parameter int REG_LENGTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam int CNT_W = (REG_LENGTH > 1) ? $clog2(REG_LENGTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                  state, state_nxt;
  logic                    sgn_q;
  logic [REG_LENGTH-1:0]   a_q, b_q;
  logic [REG_LENGTH-1:0]   acc, quo, dvs;
  logic [REG_LENGTH-1:0]   hi_q, lo_q;
  logic [CNT_W-1:0]        cnt;

  logic                    accept;
  logic                    in_signed;
  logic                    last_iter;
  logic                    div_zero;
  logic                    neg_quo, neg_rem;
  logic [REG_LENGTH:0]     shifted, diff;
  logic                    fits;
  logic [REG_LENGTH-1:0]   acc_step, quo_step;
  logic [2*REG_LENGTH-1:0] a_ext, b_ext, product;

  function automatic logic [REG_LENGTH-1:0] mag(input logic [REG_LENGTH-1:0] v,
                                                input logic                  s);
    return (s && v[REG_LENGTH-1]) ? -v : v;
  endfunction

  // op[0]=0 selects the signed flavour for both MULT and DIV.
  assign in_signed = ~bus.op[0];
  assign accept    = (state == IDLE) && bus.start && !bus.cancel;
  assign last_iter = (cnt == CNT_W'(REG_LENGTH - 1));
  assign div_zero  = (b_q == '0);
  assign neg_quo   = sgn_q & (a_q[REG_LENGTH-1] ^ b_q[REG_LENGTH-1]);
  assign neg_rem   = sgn_q & a_q[REG_LENGTH-1];

  // Restoring step: shift in the next dividend bit, keep the subtraction if it fits.
  assign shifted  = {acc, quo[REG_LENGTH-1]};
  assign diff     = shifted - {1'b0, dvs};
  assign fits     = ~diff[REG_LENGTH];
  assign acc_step = fits ? diff[REG_LENGTH-1:0] : shifted[REG_LENGTH-1:0];
  assign quo_step = {quo[REG_LENGTH-2:0], fits};

  assign a_ext   = {{REG_LENGTH{sgn_q & a_q[REG_LENGTH-1]}}, a_q};
  assign b_ext   = {{REG_LENGTH{sgn_q & b_q[REG_LENGTH-1]}}, b_q};
  assign product = a_ext * b_ext;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the processes are evaluated in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = bus.op[1] ? DIV : MUL;
      MUL:  state_nxt = DONE;
      DIV:  if (div_zero || last_iter) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A flush wins over both a new request and a completing operation.
    if (bus.cancel) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sgn_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      quo   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          sgn_q <= in_signed;
          a_q   <= bus.opA;
          b_q   <= bus.opB;
          acc   <= '0;
          quo   <= mag(bus.opA, in_signed);
          dvs   <= mag(bus.opB, in_signed);
          cnt   <= '0;
        end
        MUL: {hi_q, lo_q} <= product;
        DIV: begin
          if (div_zero) begin
            lo_q <= '1;
            hi_q <= a_q;
          end else begin
            acc <= acc_step;
            quo <= quo_step;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
              lo_q <= neg_quo ? -quo_step : quo_step;
              hi_q <= neg_rem ? -acc_step : acc_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == MUL) || (state == DIV);
  assign bus.hiWtCe   = (state == DONE);
  assign bus.loWtCe   = (state == DONE);
  assign bus.hiWtData = (state == DONE) ? hi_q : '0;
  assign bus.loWtData = (state == DONE) ? lo_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model plus a per-cycle
// compare process driven by a queue of expected write pulses and busy windows.
module tb_muldiv_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;
  int   last_due = -1;

  typedef struct {
    int          first;
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];

  muldiv_unit_if #(.REG_LENGTH(32)) bus ();

  muldiv_unit #(.REG_LENGTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s @cycle %0d: actual %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      MULT:  return 64'(sa * sb);
      MULTU: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          return {sr[31:0], sq[31:0]};
        end
        ua = ua / ub + ((ua % ub) << 32);
        return {ua[63:32], ua[31:0]};
      end
    endcase
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] b);
    if (!o[1] || b == 32'd0) return 1;
    return 32;
  endfunction

  always @(negedge clk) begin : compare
    logic        exp_busy, exp_pulse;
    logic [31:0] exp_hi, exp_lo;
    exp_busy  = 1'b0;
    exp_pulse = 1'b0;
    exp_hi    = '0;
    exp_lo    = '0;
    if (q.size() > 0) begin
      if (cyc >= q[0].first && cyc < q[0].due) exp_busy = 1'b1;
      if (cyc == q[0].due) begin
        exp_pulse = 1'b1;
        exp_hi    = q[0].hi;
        exp_lo    = q[0].lo;
      end
    end
    check("busy", 64'(bus.busy), 64'(exp_busy));
    check("wt_ce", 64'({bus.hiWtCe, bus.loWtCe}), 64'({exp_pulse, exp_pulse}));
    check("wt_data", {bus.hiWtData, bus.loWtData}, {exp_hi, exp_lo});
    if (exp_pulse) void'(q.pop_front());
  end

  // Called at a falling edge. With early=1 start is raised during the previous
  // DONE cycle, where it must be ignored, and held until the following IDLE edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input bit early, input bit noise);
    int lat, first;
    if (early) while (cyc < last_due) @(negedge clk);
    else       while (cyc <= last_due) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.opA   = a;
    bus.opB   = b;
    if (cyc == last_due) @(negedge clk);
    first = cyc + 1;
    lat   = latency(o, b);
    q.push_back('{first, first + lat, ehi, elo});
    last_due = first + lat;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 2'($urandom);
    bus.opA   = $urandom;
    bus.opB   = $urandom;
    if (noise && lat > 2) begin
      repeat (lat - 2) begin
        bus.start = 1'b1;
        bus.op    = 2'($urandom);
        bus.opA   = $urandom;
        bus.opB   = $urandom;
        @(negedge clk);
      end
      bus.start = 1'b0;
    end
  endtask

  task automatic issue_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input bit early, input bit noise);
    logic [63:0] m;
    m = model(o, a, b);
    issue(o, a, b, m[63:32], m[31:0], early, noise);
  endtask

  // Cancel sampled at the k-th edge after the accepting edge.
  task automatic issue_cancel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              input int k);
    int first;
    while (cyc <= last_due) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.opA   = a;
    bus.opB   = b;
    first = cyc + 1;
    q.push_back('{first, first + latency(o, b), 32'd0, 32'd0});
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < first + k - 1) @(negedge clk);
    bus.cancel = 1'b1;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    void'(q.pop_back());
    last_due = cyc - 1;
    @(negedge clk);
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: actual cycle budget exhausted, expected completion");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, failed + 1);
  end

  initial begin
    logic [63:0] m;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = MULT;
    bus.opA    = '0;
    bus.opB    = '0;

    // Pin the reference model against hand-computed values.
    m = model(MULT,  32'hFFFF_FFFE, 32'd3);         check("model_mult",   m, 64'hFFFF_FFFF_FFFF_FFFA);
    m = model(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); check("model_multu",  m, 64'hFFFF_FFFE_0000_0001);
    m = model(DIV,   32'hFFFF_FFF9, 32'd2);         check("model_div",    m, 64'hFFFF_FFFF_FFFF_FFFD);
    m = model(DIVU,  32'd7, 32'd2);                 check("model_divu",   m, 64'h0000_0001_0000_0003);
    m = model(DIVU,  32'h1234, 32'd0);              check("model_div0",   m, 64'h0000_1234_FFFF_FFFF);
    m = model(DIV,   32'h8000_0000, 32'hFFFF_FFFF); check("model_ovf",    m, 64'h0000_0000_8000_0000);

    @(negedge clk);
    check("reset_outputs", {31'd0, bus.busy, bus.hiWtCe, bus.loWtCe, bus.hiWtData, bus.loWtData}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases with literal expectations; the first start follows reset release.
    issue(MULT,  32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, 0, 0);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1, 0);
    issue(DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 1);
    issue(DIVU,  32'd7, 32'd2,                  32'd1, 32'd3, 1, 0);
    issue(DIVU,  32'h1234, 32'd0,               32'h1234, 32'hFFFF_FFFF, 0, 0);
    issue(DIV,   32'hFFFF_FFF0, 32'd0,          32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, 0);
    issue(DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'd0, 32'h8000_0000, 0, 0);

    // Flushes: mid-divide, on the completing divide edge, during multiply.
    issue_cancel(DIV, 32'd1000, 32'd3, 10);
    issue_cancel(DIVU, 32'hDEAD_BEEF, 32'd5, 32);
    issue_cancel(MULT, 32'd5, 32'd6, 1);
    while (cyc <= last_due) @(negedge clk);
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = MULT;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    last_due   = cyc - 1;
    issue(DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 0, 1);

    // Asynchronous reset in the middle of a divide.
    issue(DIV, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0);
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b0;
    q.delete();
    #1;
    check("async_reset_busy", 64'(bus.busy), 64'd0);
    check("async_reset_ce", 64'({bus.hiWtCe, bus.loWtCe}), 64'd0);
    check("async_reset_data", {bus.hiWtData, bus.loWtData}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_due = cyc - 1;
    issue(MULT, 32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      issue_model(2'($urandom), rand_operand(), rand_operand(),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    while (cyc <= last_due) @(negedge clk);
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
